// File: rtl/rho_engine_sched.sv
// rho_engine_sched: shares one rho/phase Hough engine between the left and right
// edge-point FIFOs in BURST-point batches. Optional WAIT timeout: RHO_SCHED_TIMEOUT_EN.
module rho_engine_sched #(
  parameter int DEPTH   = 512,
  parameter int BURST   = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        l_vld,
  input  logic [23:0] l_axis,
  input  logic        r_vld,
  input  logic [23:0] r_axis,
  output logic        eng_interest_part,
  output logic        eng_in_vld,
  output logic [23:0] eng_x_y_axis,
  input  logic        eng_out_vld,
  input  logic [7:0]  eng_phase_data,
  input  logic [27:0] eng_rho_data,
  output logic        left_vld,
  output logic [7:0]  left_phase,
  output logic [27:0] left_rho,
  output logic        right_vld,
  output logic [7:0]  right_phase,
  output logic [27:0] right_rho,
  output logic        l_ovf,
  output logic        r_ovf,
  output logic        busy,
  output logic        to_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] BURST_C    = CW'(BURST);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

  if (DEPTH < BURST || TIMEOUT < 1) begin : g_cfg_chk
    $error("rho_engine_sched: DEPTH must be >= BURST and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [23:0]   l_mem [DEPTH];
  logic [23:0]   r_mem [DEPTH];
  logic [AW-1:0] l_wp_q, l_wp_d, l_rp_q, l_rp_d;
  logic [AW-1:0] r_wp_q, r_wp_d, r_rp_q, r_rp_d;
  logic [CW-1:0] l_cnt_q, l_cnt_d, r_cnt_q, r_cnt_d;
  logic          l_wr, l_rd, r_wr, r_rd, l_rdy, r_rdy;
  logic [23:0]   rd_data;

  logic          part_q, part_d, rr_q, rr_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          in_vld_q, in_vld_d;
  logic [23:0]   xy_q, xy_d;
  logic          lres_q, lres_d, rres_q, rres_d;
  logic [7:0]    lph_q, lph_d, rph_q, rph_d;
  logic [27:0]   lrho_q, lrho_d, rrho_q, rrho_d;
  logic          l_ovf_q, l_ovf_d, r_ovf_q, r_ovf_d;
  logic          busy_q, busy_d;

`ifdef RHO_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          to_err_q, to_err_d;
`endif

  // FIFO pointer/occupancy bookkeeping; pops happen only while LOAD serves that side
  always_comb begin
    l_wr    = l_vld && (l_cnt_q != DEPTH_C);
    r_wr    = r_vld && (r_cnt_q != DEPTH_C);
    l_ovf_d = l_vld && (l_cnt_q == DEPTH_C);
    r_ovf_d = r_vld && (r_cnt_q == DEPTH_C);
    l_rd    = (state_q == S_LOAD) && !part_q;
    r_rd    = (state_q == S_LOAD) && part_q;
    l_wp_d  = l_wr ? (l_wp_q + AW'(1)) : l_wp_q;
    r_wp_d  = r_wr ? (r_wp_q + AW'(1)) : r_wp_q;
    l_rp_d  = l_rd ? (l_rp_q + AW'(1)) : l_rp_q;
    r_rp_d  = r_rd ? (r_rp_q + AW'(1)) : r_rp_q;
    l_cnt_d = l_cnt_q + CW'(l_wr) - CW'(l_rd);
    r_cnt_d = r_cnt_q + CW'(r_wr) - CW'(r_rd);
    l_rdy   = (l_cnt_q >= BURST_C);
    r_rdy   = (r_cnt_q >= BURST_C);
    if (part_q) begin
      rd_data = r_mem[r_rp_q];
    end else begin
      rd_data = l_mem[l_rp_q];
    end
  end

  // FIFO storage carries no reset; stale contents are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (l_wr) l_mem[l_wp_q] <= l_axis;
    if (r_wr) r_mem[r_wp_q] <= r_axis;
  end

  // Scheduler next-state: arbitration, burst issue and result routing
  always_comb begin
    state_d  = state_q;
    part_d   = part_q;
    rr_d     = rr_q;
    bcnt_d   = bcnt_q;
    in_vld_d = 1'b0;
    xy_d     = xy_q;
    lres_d   = 1'b0;
    rres_d   = 1'b0;
    lph_d    = lph_q;
    lrho_d   = lrho_q;
    rph_d    = rph_q;
    rrho_d   = rrho_q;
`ifdef RHO_SCHED_TIMEOUT_EN
    tmo_d    = tmo_q;
    to_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (l_rdy || r_rdy) begin
          state_d = S_LOAD;
          bcnt_d  = BW'(0);
          // rr_q names the side preferred when both are ready
          if (l_rdy && r_rdy) begin
            part_d = rr_q;
          end else begin
            part_d = r_rdy;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        in_vld_d = 1'b1;
        xy_d     = rd_data;
        bcnt_d   = bcnt_q + BW'(1);
`ifdef RHO_SCHED_TIMEOUT_EN
        tmo_d    = TW'(0);
`endif
        if (bcnt_q == BURST_LAST) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_WAIT: begin
        if (eng_out_vld) begin
          if (part_q) begin
            rres_d = 1'b1;
            rph_d  = eng_phase_data;
            rrho_d = eng_rho_data;
          end else begin
            lres_d = 1'b1;
            lph_d  = eng_phase_data;
            lrho_d = eng_rho_data;
          end
          state_d = S_IDLE;
          rr_d    = ~part_q;
        end
`ifdef RHO_SCHED_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          to_err_d = 1'b1;
          state_d  = S_IDLE;
          rr_d     = ~part_q;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`else
        else begin
          state_d = S_WAIT;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; async reset aborts any batch in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      l_wp_q   <= AW'(0);
      l_rp_q   <= AW'(0);
      r_wp_q   <= AW'(0);
      r_rp_q   <= AW'(0);
      l_cnt_q  <= CW'(0);
      r_cnt_q  <= CW'(0);
      part_q   <= 1'b0;
      rr_q     <= 1'b0;
      bcnt_q   <= BW'(0);
      in_vld_q <= 1'b0;
      xy_q     <= 24'd0;
      lres_q   <= 1'b0;
      rres_q   <= 1'b0;
      lph_q    <= 8'd0;
      rph_q    <= 8'd0;
      lrho_q   <= 28'd0;
      rrho_q   <= 28'd0;
      l_ovf_q  <= 1'b0;
      r_ovf_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      l_wp_q   <= l_wp_d;
      l_rp_q   <= l_rp_d;
      r_wp_q   <= r_wp_d;
      r_rp_q   <= r_rp_d;
      l_cnt_q  <= l_cnt_d;
      r_cnt_q  <= r_cnt_d;
      part_q   <= part_d;
      rr_q     <= rr_d;
      bcnt_q   <= bcnt_d;
      in_vld_q <= in_vld_d;
      xy_q     <= xy_d;
      lres_q   <= lres_d;
      rres_q   <= rres_d;
      lph_q    <= lph_d;
      rph_q    <= rph_d;
      lrho_q   <= lrho_d;
      rrho_q   <= rrho_d;
      l_ovf_q  <= l_ovf_d;
      r_ovf_q  <= r_ovf_d;
      busy_q   <= busy_d;
    end
  end

`ifdef RHO_SCHED_TIMEOUT_EN
  // WAIT watchdog counter and its error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q    <= TW'(0);
      to_err_q <= 1'b0;
    end else begin
      tmo_q    <= tmo_d;
      to_err_q <= to_err_d;
    end
  end
  assign to_err = to_err_q;
`else
  assign to_err = 1'b0;
`endif

  assign eng_interest_part = part_q;
  assign eng_in_vld        = in_vld_q;
  assign eng_x_y_axis      = xy_q;
  assign left_vld          = lres_q;
  assign left_phase        = lph_q;
  assign left_rho          = lrho_q;
  assign right_vld         = rres_q;
  assign right_phase       = rph_q;
  assign right_rho         = rrho_q;
  assign l_ovf             = l_ovf_q;
  assign r_ovf             = r_ovf_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_rho_engine_sched.sv
// Directed/randomized bench for rho_engine_sched: queue-based model of the two FIFOs,
// round-robin arbitration and result routing, checked with immediate assertions.
module tb_rho_engine_sched;
  localparam int DEPTH = 512;
  localparam int BURST = 256;

  logic        clk, rst_n;
  logic        l_vld, r_vld, eng_out_vld;
  logic [23:0] l_axis, r_axis;
  logic [7:0]  eng_phase_data;
  logic [27:0] eng_rho_data;
  logic        eng_interest_part, eng_in_vld;
  logic [23:0] eng_x_y_axis;
  logic        left_vld, right_vld, l_ovf, r_ovf, busy, to_err;
  logic [7:0]  left_phase, right_phase;
  logic [27:0] left_rho, right_rho;

  rho_engine_sched #(.DEPTH(DEPTH), .BURST(BURST), .TIMEOUT(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .l_vld(l_vld), .l_axis(l_axis), .r_vld(r_vld), .r_axis(r_axis),
    .eng_interest_part(eng_interest_part), .eng_in_vld(eng_in_vld),
    .eng_x_y_axis(eng_x_y_axis), .eng_out_vld(eng_out_vld),
    .eng_phase_data(eng_phase_data), .eng_rho_data(eng_rho_data),
    .left_vld(left_vld), .left_phase(left_phase), .left_rho(left_rho),
    .right_vld(right_vld), .right_phase(right_phase), .right_rho(right_rho),
    .l_ovf(l_ovf), .r_ovf(r_ovf), .busy(busy), .to_err(to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] lq[$];
  logic [23:0] rq[$];
  logic        rr_pref, served;
  logic [7:0]  m_lph, m_rph;
  logic [27:0] m_lrho, m_rrho;
  int          n_chk, n_pass, n_fail, n_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_held();
    check("held_lph", left_phase, m_lph);
    check("held_lrho", left_rho, m_lrho);
    check("held_rph", right_phase, m_rph);
    check("held_rrho", right_rho, m_rrho);
  endtask

  task automatic model_clear();
    lq.delete();
    rq.delete();
    rr_pref = 1'b0;
    m_lph = 8'd0; m_rph = 8'd0; m_lrho = 28'd0; m_rrho = 28'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    l_vld = 1'b0; r_vld = 1'b0; eng_out_vld = 1'b0;
    model_clear();
    @(negedge clk);
    check("rst_in_vld", eng_in_vld, 1'b0);
    check("rst_part", eng_interest_part, 1'b0);
    check("rst_xy", eng_x_y_axis, 24'd0);
    check("rst_lvld", left_vld, 1'b0);
    check("rst_rvld", right_vld, 1'b0);
    check("rst_lovf", l_ovf, 1'b0);
    check("rst_rovf", r_ovf, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_to_err", to_err, 1'b0);
    check_held();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One input cycle; ovf for a dropped point is visible one cycle later
  task automatic push(input logic lv, input logic [23:0] ld, input logic rv, input logic [23:0] rd);
    logic exp_l, exp_r;
    l_vld = lv; l_axis = ld; r_vld = rv; r_axis = rd;
    @(negedge clk);
    exp_l = lv && (lq.size() == DEPTH);
    exp_r = rv && (rq.size() == DEPTH);
    if (lv && !exp_l) lq.push_back(ld);
    if (rv && !exp_r) rq.push_back(rd);
    check("l_ovf", l_ovf, exp_l);
    check("r_ovf", r_ovf, exp_r);
    if (r_ovf === 1'b1) n_ovf++;
    l_vld = 1'b0; r_vld = 1'b0;
  endtask

  function automatic logic model_pick();
    logic l_ok, r_ok;
    l_ok = (lq.size() >= BURST);
    r_ok = (rq.size() >= BURST);
    if (l_ok && r_ok) return rr_pref;
    return r_ok;
  endfunction

  task automatic run_burst(input int inj_at, input int rst_at);
    logic        side;
    logic [23:0] exp_pt;
    int          wait_n;
    side   = model_pick();
    served = side;
    wait_n = 0;
    while (eng_in_vld !== 1'b1 && wait_n < 8) begin
      @(negedge clk);
      wait_n++;
    end
    check("burst_start", eng_in_vld, 1'b1);
    if (eng_in_vld !== 1'b1) return;
    for (int k = 0; k < BURST; k++) begin
      if (side) exp_pt = rq.pop_front();
      else      exp_pt = lq.pop_front();
      check("burst_vld", eng_in_vld, 1'b1);
      check("burst_part", eng_interest_part, side);
      check("burst_pt", eng_x_y_axis, exp_pt);
      check("burst_busy", busy, 1'b1);
      check("burst_lvld", left_vld, 1'b0);
      check("burst_rvld", right_vld, 1'b0);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_in_vld", eng_in_vld, 1'b0);
        check("abort_busy", busy, 1'b0);
        return;
      end
      eng_out_vld = (k == inj_at);
      @(negedge clk);
    end
    eng_out_vld = 1'b0;
    check("burst_end", eng_in_vld, 1'b0);
    check("wait_busy", busy, 1'b1);
    check("wait_part", eng_interest_part, side);
    check("wait_to_err", to_err, 1'b0);
  endtask

  task automatic respond(input logic [7:0] ph, input logic [27:0] rh);
    eng_out_vld = 1'b1; eng_phase_data = ph; eng_rho_data = rh;
    @(negedge clk);
    eng_out_vld = 1'b0;
    if (served) begin m_rph = ph; m_rrho = rh; end
    else        begin m_lph = ph; m_lrho = rh; end
    rr_pref = ~served;
    check("res_lvld", left_vld, !served);
    check("res_rvld", right_vld, served);
    check_held();
    check("res_busy", busy, 1'b0);
    @(negedge clk);
    check("res_lvld_end", left_vld, 1'b0);
    check("res_rvld_end", right_vld, 1'b0);
    check_held();
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0; n_ovf = 0;
    rst_n = 1'b1; l_vld = 1'b0; r_vld = 1'b0; eng_out_vld = 1'b0;
    l_axis = 24'd0; r_axis = 24'd0; eng_phase_data = 8'd0; eng_rho_data = 28'd0;
    served = 1'b0;
    #2;
    do_reset();

    // Single left batch of (x=i, y=2i)
    for (int i = 0; i < BURST; i++) push(1'b1, {12'(i), 12'(2 * i)}, 1'b0, 24'd0);
    run_burst(-1, -1);
    respond(8'd80, 28'd300);

    // Both sides full before arbitration: left then right
    do_reset();
    for (int i = 0; i < BURST; i++) push(1'b1, 24'($urandom()), 1'b1, 24'($urandom()));
    run_burst(-1, -1);
    check("order_first", served, 1'b0);
    respond(8'($urandom()), 28'($urandom()));
    run_burst(-1, -1);
    check("order_second", served, 1'b1);
    respond(8'($urandom()), 28'($urandom()));

    // Right overflow while the engine holds a left batch
    for (int i = 0; i < BURST; i++) push(1'b1, 24'($urandom()), 1'b0, 24'd0);
    run_burst(-1, -1);
    for (int i = 0; i < 600; i++) push(1'b0, 24'd0, 1'b1, 24'($urandom()));
    check("ovf_count", n_ovf, 88);
    check("ovf_accepted", rq.size(), DEPTH);
    respond(8'($urandom()), 28'($urandom()));
    for (int b = 0; b < 2; b++) begin
      run_burst(-1, -1);
      respond(8'($urandom()), 28'($urandom()));
    end
    check("drain_empty", rq.size(), 0);

    // Engine result during LOAD is ignored
    for (int i = 0; i < BURST; i++) push(1'b1, 24'($urandom()), 1'b0, 24'd0);
    run_burst(50, -1);
    respond(8'($urandom()), 28'($urandom()));

    // Async reset at point 100 of a burst
    for (int i = 0; i < BURST; i++) push(1'b1, 24'($urandom()), 1'b0, 24'd0);
    run_burst(-1, 100);
    do_reset();
    for (int i = 0; i < BURST - 1; i++) push(1'b1, 24'($urandom()), 1'b0, 24'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_idle_vld", eng_in_vld, 1'b0);
      check("post_rst_idle_busy", busy, 1'b0);
    end
    push(1'b1, 24'($urandom()), 1'b0, 24'd0);
    run_burst(-1, -1);
    respond(8'($urandom()), 28'($urandom()));
    check("final_to_err", to_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
